// File: rtl/id_pkg.sv
// Shared definitions for the decode-stage control slice: opcodes, the NOP
// word that fills an empty IF/ID register, the sequencing states, and the
// source-register usage decode.
package id_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } id_state_e;

   // True when the opcode reads rs1 (instr[19:15]).
   function automatic logic usesRs1(input logic [6:0] opcode);
      return (opcode == OP_R)     || (opcode == OP_IMM)   ||
             (opcode == OP_LOAD)  || (opcode == OP_JALR)  ||
             (opcode == OP_STORE) || (opcode == OP_BRANCH);
   endfunction

   // True when the opcode reads rs2 (instr[24:20]).
   function automatic logic usesRs2(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Load-use hazard detector: flags when the instruction sitting in ID reads a
// register that the load currently in EX has not yet produced. Purely
// combinational so it can also be reused for forwarding qualification.
module id_hazard_detect
   import id_pkg::*;
(
   input  logic [31:0] id_instr_i,
   input  logic        reg_valid_i,
   input  logic        ex_valid_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rd_i,
   output logic        hazard_stall_o
);

   logic       useRs1;
   logic       useRs2;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       unusedBits;

   assign rs1        = id_instr_i[19:15];
   assign rs2        = id_instr_i[24:20];
   assign unusedBits = ^{id_instr_i[31:25], id_instr_i[14:7]};

   // Decode which source fields are real and compare them with the EX load's rd;
   // x0 is never a real dependency.
   always_comb begin
      useRs1         = usesRs1(id_instr_i[6:0]);
      useRs2         = usesRs2(id_instr_i[6:0]);
      hazard_stall_o = reg_valid_i & ex_valid_i & ex_memread_i & (ex_rd_i != 5'd0) &
                       ((useRs1 & (rs1 == ex_rd_i)) | (useRs2 & (rs2 == ex_rd_i)));
   end

endmodule

// File: rtl/id_pipe_ctrl.sv
// Decode-stage sequencing controller. Owns the IF/ID register, handshakes with
// fetch and execute, inserts a bubble on load-use hazards, discards wrong-path
// fetch beats after a redirect, and counts stall cycles.
module id_pipe_ctrl
   import id_pkg::*;
#(
   parameter int FLUSH_SHADOW = 1,
   parameter int PERF_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [31:0]       id_pc,
   input  logic              ex_valid,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rd,
   input  logic              redirect,
   output logic              hazard_stall,
   output logic              squashing,
   output logic [PERF_W-1:0] stall_cycles
);

   id_state_e         state_q,    state_d;
   logic [2:0]        cnt_q,      cnt_d;
   logic              regValid_q, regValid_d;
   logic [31:0]       instr_q,    instr_d;
   logic [31:0]       pc_q,       pc_d;
   logic [PERF_W-1:0] stall_q,    stall_d;
   logic              fire;

   id_hazard_detect uHazard (
      .id_instr_i     (instr_q),
      .reg_valid_i    (regValid_q),
      .ex_valid_i     (ex_valid),
      .ex_memread_i   (ex_memread),
      .ex_rd_i        (ex_rd),
      .hazard_stall_o (hazard_stall)
   );

   assign id_valid     = regValid_q & ~hazard_stall & ~redirect;
   assign fire         = id_valid & id_ready;
   assign squashing    = (state_q == SQUASH);
   assign if_ready     = ~regValid_q | fire | redirect | squashing;
   assign id_instr     = instr_q;
   assign id_pc        = pc_q;
   assign stall_cycles = stall_q;

   // Next-state for the IF/ID register and squash FSM; redirect wins over all,
   // then squash discards, then a new beat loads, then a lone transfer empties.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      regValid_d = regValid_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      if (redirect) begin
         regValid_d = 1'b0;
         cnt_d      = 3'(FLUSH_SHADOW);
         state_d    = (FLUSH_SHADOW == 0) ? RUN : SQUASH;
      end else if (state_q == SQUASH) begin
         regValid_d = 1'b0;
         cnt_d      = cnt_q - 3'd1;
         if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      end else if (if_valid && if_ready) begin
         regValid_d = 1'b1;
         instr_d    = if_instr;
         pc_d       = if_pc;
      end else if (fire) begin
         regValid_d = 1'b0;
         instr_d    = NOP_INSTR;
      end
   end

   // Saturating count of cycles spent holding a load-use bubble.
   always_comb begin
      stall_d = stall_q;
      if (hazard_stall && (stall_q != {PERF_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // State registers with asynchronous active-low reset to an empty, NOP-filled stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         cnt_q      <= 3'd0;
         regValid_q <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_q       <= 32'd0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         regValid_q <= regValid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         stall_q    <= stall_d;
      end
   end

endmodule

// File: tb/tb_id_pipe_ctrl.sv
// Directed bench for id_pipe_ctrl. A main instance (FLUSH_SHADOW=1, PERF_W=16)
// and a second instance (FLUSH_SHADOW=2, PERF_W=4) share all inputs so the
// squash length and counter saturation can be observed side by side.
module tb_id_pipe_ctrl;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ADD    = 32'h0072_8333; // add x6,x5,x7
   localparam logic [31:0] ADD_X0 = 32'h0070_0333; // add x6,x0,x7
   localparam logic [31:0] LUI_X5 = 32'h0002_82B7; // lui x5, bits[19:15]=5
   localparam logic [31:0] SW_X5  = 32'h0051_2023; // sw x5,0(x2)

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        ex_valid;
   logic        ex_memread;
   logic [4:0]  ex_rd;
   logic        redirect;

   logic        if_ready,  satIfReady;
   logic        id_valid,  satIdValid;
   logic [31:0] id_instr,  satIdInstr;
   logic [31:0] id_pc,     satIdPc;
   logic        hazard_stall, satHazard;
   logic        squashing, satSquashing;
   logic [15:0] stall_cycles;
   logic [3:0]  satStall;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   id_pipe_ctrl #(.FLUSH_SHADOW(1), .PERF_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_pc(id_pc), .ex_valid(ex_valid), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .redirect(redirect), .hazard_stall(hazard_stall),
      .squashing(squashing), .stall_cycles(stall_cycles)
   );

   id_pipe_ctrl #(.FLUSH_SHADOW(2), .PERF_W(4)) dutSat (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(satIfReady),
      .if_instr(if_instr), .if_pc(if_pc), .id_valid(satIdValid), .id_ready(id_ready),
      .id_instr(satIdInstr), .id_pc(satIdPc), .ex_valid(ex_valid), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .redirect(redirect), .hazard_stall(satHazard),
      .squashing(satSquashing), .stall_cycles(satStall)
   );

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      if_valid   = 1'b0;
      if_instr   = NOP;
      if_pc      = 32'd0;
      id_ready   = 1'b0;
      ex_valid   = 1'b0;
      ex_memread = 1'b0;
      ex_rd      = 5'd0;
      redirect   = 1'b0;
   endtask

   task automatic doReset();
      idleInputs();
      rst_n = 1'b0;
      nextCycle();
      rst_n = 1'b1;
   endtask

   task automatic loadBeat(input logic [31:0] instr, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
      id_ready = 1'b0;
      nextCycle();
      if_valid = 1'b0;
   endtask

   task automatic test_reset();
      idleInputs();
      rst_n = 1'b0;
      #3;
      testsRun++;
      if (id_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_id_valid got %b want 0", id_valid); end
      testsRun++;
      if (if_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_if_ready got %b want 1", if_ready); end
      testsRun++;
      if (id_instr !== NOP) begin testsFailed++; $display("[TB] FAIL reset_id_instr got %h want %h", id_instr, NOP); end
      testsRun++;
      if (id_pc !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_id_pc got %h want 0", id_pc); end
      testsRun++;
      if ({hazard_stall, squashing} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_flags got %b%b want 00", hazard_stall, squashing); end
      testsRun++;
      if (stall_cycles !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_stall got %0d want 0", stall_cycles); end
      nextCycle();
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      doReset();
      loadBeat(ADD, 32'h0);
      if_valid   = 1'b1;
      if_instr   = NOP;
      if_pc      = 32'h4;
      ex_valid   = 1'b1;
      ex_memread = 1'b1;
      ex_rd      = 5'd5;
      id_ready   = 1'b1;
      #1;
      testsRun++;
      if ({hazard_stall, id_valid, if_ready} !== 3'b100) begin testsFailed++; $display("[TB] FAIL lu_stall got haz/val/rdy=%b%b%b want 100", hazard_stall, id_valid, if_ready); end
      nextCycle();
      ex_valid   = 1'b0;
      ex_memread = 1'b0;
      #1;
      testsRun++;
      if ({hazard_stall, id_valid, if_ready} !== 3'b011) begin testsFailed++; $display("[TB] FAIL lu_issue got haz/val/rdy=%b%b%b want 011", hazard_stall, id_valid, if_ready); end
      testsRun++;
      if (id_instr !== ADD) begin testsFailed++; $display("[TB] FAIL lu_instr got %h want %h", id_instr, ADD); end
      testsRun++;
      if (stall_cycles !== 16'd1) begin testsFailed++; $display("[TB] FAIL lu_stall_count got %0d want 1", stall_cycles); end
      nextCycle();
      if_valid = 1'b0;
      testsRun++;
      if ({id_valid, id_pc} !== {1'b1, 32'h4}) begin testsFailed++; $display("[TB] FAIL lu_next got valid=%b pc=%h want 1/4", id_valid, id_pc); end
      nextCycle();
      testsRun++;
      if ({id_valid, id_instr} !== {1'b0, NOP}) begin testsFailed++; $display("[TB] FAIL lu_drain got valid=%b instr=%h want 0/%h", id_valid, id_instr, NOP); end
   endtask

   task automatic test_no_false_hazard();
      logic [31:0] instrs [3];
      logic [4:0]  rds    [3];
      logic        expHaz [3];
      instrs = '{ADD_X0, LUI_X5, SW_X5};
      rds    = '{5'd0, 5'd5, 5'd5};
      expHaz = '{1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         doReset();
         loadBeat(instrs[k], 32'h40);
         ex_valid   = 1'b1;
         ex_memread = 1'b1;
         ex_rd      = rds[k];
         id_ready   = 1'b1;
         #1;
         testsRun++;
         if ({hazard_stall, id_valid} !== {expHaz[k], ~expHaz[k]}) begin
            testsFailed++;
            $display("[TB] FAIL nohaz_case%0d got haz=%b valid=%b want haz=%b", k, hazard_stall, id_valid, expHaz[k]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      doReset();
      loadBeat(ADD, 32'h80);
      ex_valid   = 1'b1;
      ex_memread = 1'b1;
      ex_rd      = 5'd5;
      nextCycle();
      #2;
      rst_n = 1'b0;
      #1;
      testsRun++;
      if ({id_valid, id_instr, id_pc} !== {1'b0, NOP, 32'd0}) begin testsFailed++; $display("[TB] FAIL midreset_reg got valid=%b instr=%h pc=%h want 0/%h/0", id_valid, id_instr, id_pc, NOP); end
      testsRun++;
      if (stall_cycles !== 16'd0) begin testsFailed++; $display("[TB] FAIL midreset_stall got %0d want 0", stall_cycles); end
      nextCycle();
      rst_n = 1'b1;
      idleInputs();
   endtask

   task automatic test_redirect();
      doReset();
      loadBeat(ADD_X0, 32'h100);
      redirect = 1'b1;
      if_valid = 1'b1;
      if_pc    = 32'h104;
      if_instr = 32'h0010_0013;
      #1;
      testsRun++;
      if ({id_valid, if_ready, squashing} !== 3'b010) begin testsFailed++; $display("[TB] FAIL redir_cycle got val/rdy/sq=%b%b%b want 010", id_valid, if_ready, squashing); end
      nextCycle();
      redirect = 1'b0;
      if_pc    = 32'h108;
      if_instr = 32'h0020_0013;
      #1;
      testsRun++;
      if ({id_valid, if_ready, squashing, satSquashing} !== 4'b0111) begin testsFailed++; $display("[TB] FAIL redir_squash got val/rdy/sq/satsq=%b%b%b%b want 0111", id_valid, if_ready, squashing, satSquashing); end
      nextCycle();
      if_pc    = 32'h200;
      if_instr = 32'h0030_0013;
      #1;
      testsRun++;
      if ({id_valid, if_ready, squashing, satSquashing} !== 4'b0101) begin testsFailed++; $display("[TB] FAIL redir_target got val/rdy/sq/satsq=%b%b%b%b want 0101", id_valid, if_ready, squashing, satSquashing); end
      nextCycle();
      if_valid = 1'b0;
      #1;
      testsRun++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h200, 32'h0030_0013}) begin testsFailed++; $display("[TB] FAIL redir_load got valid=%b pc=%h instr=%h want 1/200/00300013", id_valid, id_pc, id_instr); end
      testsRun++;
      if (satSquashing !== 1'b0) begin testsFailed++; $display("[TB] FAIL redir_sat_done got %b want 0", satSquashing); end
   endtask

   task automatic test_redirect_in_squash();
      doReset();
      redirect = 1'b1;
      nextCycle();
      nextCycle();
      redirect = 1'b0;
      #1;
      testsRun++;
      if (squashing !== 1'b1) begin testsFailed++; $display("[TB] FAIL resquash_hold got %b want 1", squashing); end
      nextCycle();
      testsRun++;
      if (squashing !== 1'b0) begin testsFailed++; $display("[TB] FAIL resquash_exit got %b want 0", squashing); end
   endtask

   task automatic test_back_to_back();
      logic        pat [8];
      logic        expValid;
      logic [31:0] expPc;
      logic [31:0] nextBeat;
      logic [31:0] expFirePc;
      logic        expFire;
      logic        expIfReady;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      doReset();
      expValid  = 1'b0;
      expPc     = 32'd0;
      nextBeat  = 32'd0;
      expFirePc = 32'd0;
      for (int i = 0; i < 8; i++) begin
         if_valid = 1'b1;
         if_pc    = nextBeat << 2;
         if_instr = NOP | (nextBeat << 20);
         id_ready = pat[i];
         #1;
         expFire    = expValid & pat[i];
         expIfReady = ~expValid | expFire;
         testsRun++;
         if ({id_valid, if_ready} !== {expValid, expIfReady}) begin testsFailed++; $display("[TB] FAIL b2b_hs%0d got val/rdy=%b%b want %b%b", i, id_valid, if_ready, expValid, expIfReady); end
         if (expValid) begin
            testsRun++;
            if (id_instr !== (NOP | ((expPc >> 2) << 20))) begin testsFailed++; $display("[TB] FAIL b2b_instr%0d got %h want %h", i, id_instr, NOP | ((expPc >> 2) << 20)); end
         end
         if (expFire) begin
            testsRun++;
            if (id_pc !== expFirePc) begin testsFailed++; $display("[TB] FAIL b2b_order%0d got pc %h want %h", i, id_pc, expFirePc); end
            expFirePc = expFirePc + 32'd4;
         end
         if (expIfReady) begin
            expValid = 1'b1;
            expPc    = nextBeat << 2;
            nextBeat = nextBeat + 32'd1;
         end
         nextCycle();
      end
      if_valid = 1'b0;
      id_ready = 1'b0;
   endtask

   task automatic test_saturation();
      doReset();
      loadBeat(ADD, 32'h0);
      ex_valid   = 1'b1;
      ex_memread = 1'b1;
      ex_rd      = 5'd5;
      repeat (15) nextCycle();
      testsRun++;
      if (satStall !== 4'd15) begin testsFailed++; $display("[TB] FAIL sat_reach got %0d want 15", satStall); end
      repeat (5) nextCycle();
      testsRun++;
      if (satStall !== 4'd15) begin testsFailed++; $display("[TB] FAIL sat_hold got %0d want 15", satStall); end
      testsRun++;
      if (stall_cycles !== 16'd20) begin testsFailed++; $display("[TB] FAIL sat_wide got %0d want 20", stall_cycles); end
      idleInputs();
   endtask

   // Run every scenario in order, then report.
   initial begin
      rst_n = 1'b1;
      idleInputs();
      #2;
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_reset_midstream();
      test_redirect();
      test_redirect_in_squash();
      test_back_to_back();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
